// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and iteration constants shared by the multiply/divide unit
package muldiv_pkg;
   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_DIVU = 2'b11;
   localparam int ITER = 32;
   localparam int CNT_W = $clog2(ITER);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add multiply or restoring-divide iteration
// Divide path (trial subtract, quotient bit) exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
   parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
   input  logic             isDiv,
   output logic             qBit,
`endif
   input  logic [WIDTH-1:0] hiIn,
   input  logic [WIDTH-1:0] loIn,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut
);
   logic [WIDTH:0] sum;
   assign sum = {1'b0, hiIn} + {1'b0, loIn[0] ? opnd : {WIDTH{1'b0}}};
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] trial, diff;
   assign trial = {hiIn, loIn[WIDTH-1]};
   // remainder < divisor keeps trial < 2*divisor, so bit WIDTH of diff is a clean borrow
   assign diff = trial - {1'b0, opnd};
   assign qBit = isDiv & ~diff[WIDTH];
   assign hiOut = !isDiv ? sum[WIDTH:1] : qBit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   assign loOut = isDiv ? {loIn[WIDTH-2:0], 1'b0} : {sum[0], loIn[WIDTH-1:1]};
`else
   assign hiOut = sum[WIDTH:1];
   assign loOut = {sum[0], loIn[WIDTH-1:1]};
`endif
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide with HI/LO registers and MTHI/MTLO writes
// MULDIV_DIV_EN enables the divide datapath; without it DIV/DIVU complete as one-cycle no-ops.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   state_t state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] accHi, accLo, opnd, absRs, absRt, stepHi, stepLo, nextLo, fixHi, fixLo;
   logic [2*WIDTH-1:0] prod;
   logic negRes, nopPend, accept, runOp, rsNeg, rtNeg, isSigned;
   assign isSigned = op == OP_MULT || op == OP_DIV;
   assign rsNeg = isSigned & rs_data[WIDTH-1];
   assign rtNeg = isSigned & rt_data[WIDTH-1];
   assign absRs = rsNeg ? -rs_data : rs_data;
   assign absRt = rtNeg ? -rt_data : rt_data;
   assign accept = start && (state == IDLE || state == FIX);
   assign prod = negRes ? -{accHi, accLo} : {accHi, accLo};
`ifdef MULDIV_DIV_EN
   logic isDiv, negRem, divZero, qBit;
   logic [WIDTH-1:0] rsRaw;
   assign runOp = 1'b1;
   assign nextLo = stepLo | WIDTH'(qBit);
   assign fixHi = !isDiv ? prod[2*WIDTH-1:WIDTH] : divZero ? rsRaw : negRem ? -accHi : accHi;
   assign fixLo = !isDiv ? prod[WIDTH-1:0] : divZero ? '1 : negRes ? -accLo : accLo;
   muldiv_step #(.WIDTH(WIDTH)) step (
      .isDiv(isDiv),
      .qBit(qBit),
      .hiIn(accHi),
      .loIn(accLo),
      .opnd(opnd),
      .hiOut(stepHi),
      .loOut(stepLo)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         isDiv <= 1'b0;
         negRem <= 1'b0;
         divZero <= 1'b0;
         rsRaw <= '0;
      end else if (accept) begin
         isDiv <= op[1];
         negRem <= rsNeg;
         divZero <= rt_data == '0;
         rsRaw <= rs_data;
      end
`else
   assign runOp = !op[1];
   assign nextLo = stepLo;
   assign fixHi = prod[2*WIDTH-1:WIDTH];
   assign fixLo = prod[WIDTH-1:0];
   muldiv_step #(.WIDTH(WIDTH)) step (
      .hiIn(accHi),
      .loIn(accLo),
      .opnd(opnd),
      .hiOut(stepHi),
      .loOut(stepLo)
   );
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         count <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         nopPend <= 1'b0;
         hi <= '0;
         lo <= '0;
         accHi <= '0;
         accLo <= '0;
         opnd <= '0;
         negRes <= 1'b0;
      end else begin
         done <= state == FIX || nopPend;
         nopPend <= accept && !runOp;
         if (state == FIX) begin
            hi <= fixHi;
            lo <= fixLo;
         end else if (state == IDLE && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
         if (state == RUN) begin
            accHi <= stepHi;
            accLo <= nextLo;
            count <= count + 1'b1;
            if (count == CNT_W'(ITER - 1)) state <= FIX;
         end else if (accept) begin
            accHi <= '0;
            accLo <= absRs;
            opnd <= absRt;
            negRes <= rsNeg ^ rtNeg;
            count <= '0;
            busy <= runOp;
            state <= runOp ? RUN : IDLE;
         end else begin
            busy <= 1'b0;
            state <= IDLE;
         end
      end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
   import muldiv_pkg::*;
   localparam int W = 32;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0] op = 2'b00;
   logic [W-1:0] rs_data = '0, rt_data = '0, wdata = '0;
   logic busy, done;
   logic [W-1:0] hi, lo;
   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int cyc;
      logic busyAfter;
   } exp_t;
   exp_t sb[$];
   exp_t mon;
   int checks = 0, failures = 0, cyc = 0;
   logic [W-1:0] mHi = '0, mLo = '0, oldHi, oldLo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .op(op),
      .rs_data(rs_data),
      .rt_data(rt_data),
      .hi_we(hi_we),
      .lo_we(lo_we),
      .wdata(wdata),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // {HI, LO} straight from the arithmetic definition of each op
   function automatic logic [2*W-1:0] model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
      longint p;
      int q, r;
      case (o)
         OP_MULT: begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            return 64'(p);
         end
         OP_MULTU: return {32'b0, a} * {32'b0, b};
         OP_DIV: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = signed'(a) / signed'(b);
            r = signed'(a) % signed'(b);
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   always @(negedge clk)
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done: got done=1 want no pending result (cycle %0d)", cyc);
         end else begin
            mon = sb.pop_front();
            check("done_cycle", W'(cyc), W'(mon.cyc));
            check("hi", hi, mon.hi);
            check("lo", lo, mon.lo);
            check("busy_at_done", W'(busy), W'(mon.busyAfter));
         end
      end

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, logic follow);
      logic [2*W-1:0] r;
      logic run;
`ifdef MULDIV_DIV_EN
      run = 1'b1;
`else
      run = !o[1];
`endif
      r = run ? model(o, a, b) : {mHi, mLo};
      start = 1'b1;
      op = o;
      rs_data = a;
      rt_data = b;
      sb.push_back('{r[2*W-1:W], r[W-1:0], cyc + (run ? 34 : 2), follow});
      mHi = r[2*W-1:W];
      mLo = r[W-1:0];
      @(negedge clk);
      start = 1'b0;
      rs_data = W'($urandom);
      rt_data = W'($urandom);
      op = 2'($urandom);
      check("busy_after_accept", W'(busy), W'(run));
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d results outstanding want 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
      rst = 1'b0;
      @(negedge clk);
      issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
      drain(60);
      check("multu_hi", hi, 32'h00000001);
      check("multu_lo", lo, 32'hFFFFFFFE);
      issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
      drain(60);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFF1);
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
      drain(60);
`ifdef MULDIV_DIV_EN
      check("div_hi", hi, 32'hFFFFFFFF);
      check("div_lo", lo, 32'hFFFFFFFD);
      issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
      drain(60);
      check("divz_hi", hi, 32'd7);
      check("divz_lo", lo, 32'hFFFFFFFF);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      drain(60);
      check("divovf_hi", hi, 32'h0);
      check("divovf_lo", lo, 32'h80000000);
`else
      check("divnop_hi", hi, 32'hFFFFFFFF);
      check("divnop_lo", lo, 32'hFFFFFFF1);
`endif
      // start and MTHI/MTLO at T+5 must be ignored; HI/LO hold old values mid-run
      oldHi = mHi;
      oldLo = mLo;
      issue(OP_MULT, 32'd1234567, 32'hFFFFFFA7, 1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1;
      op = OP_MULTU;
      rs_data = 32'd99;
      rt_data = 32'd77;
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("midrun_hi", hi, oldHi);
      check("midrun_lo", lo, oldLo);
      drain(60);
      hi_we = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi_hi", hi, 32'h1234);
      check("mthi_lo", lo, mLo);
      check("mthi_done", W'(done), '0);
      mHi = 32'h1234;
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hABCD0000;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mthilo_hi", hi, 32'hABCD0000);
      check("mthilo_lo", lo, 32'hABCD0000);
      mHi = 32'hABCD0000;
      mLo = 32'hABCD0000;
      // write coinciding with start is dropped
      oldHi = mHi;
      oldLo = mLo;
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEAD0001;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("startwins_hi", hi, oldHi);
      check("startwins_lo", lo, oldLo);
      drain(60);
      // back-to-back: second start at the completing edge
      issue(OP_MULT, 32'h7FFFFFFF, 32'h80000000, 1'b1);
      repeat (32) @(negedge clk);
      issue(OP_MULTU, 32'h0000FFFF, 32'h00010001, 1'b0);
      drain(60);
      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom), pick(), pick(), 1'b0);
         drain(60);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      // asynchronous reset mid-operation
      issue(OP_MULT, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", W'(busy), '0);
      check("abort_done", W'(done), '0);
      check("abort_hi", hi, '0);
      check("abort_lo", lo, '0);
      sb.delete();
      mHi = '0;
      mLo = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(OP_MULTU, 32'd3, 32'd4, 1'b0);
      drain(60);
      check("post_rst_hi", hi, 32'd0);
      check("post_rst_lo", lo, 32'd12);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
